// File: rtl/fmt_num_ascii.sv
// Streaming binary-to-ASCII number formatter: decimal (double-dabble), hex or binary, padded or minimal width.
// Optional signed decimal support is enabled by defining FMT_NUM_SIGNED_EN.
module fmt_num_ascii #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [1:0]       in_fmt,
  input  logic             in_pad,
`ifdef FMT_NUM_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy
);

  // Number of decimal digits needed for the largest unsigned WIDTH-bit value
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned m;
    int unsigned     n;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (m != 64'd0) begin
        n = n + 1;
        m = m / 64'd10;
      end
    end
    return n;
  endfunction

  localparam int unsigned DEC_DIG = dec_digits(WIDTH);
  localparam int unsigned HEX_DIG = (WIDTH + 3) / 4;
  localparam int unsigned NDIG    = (WIDTH > DEC_DIG) ? WIDTH : DEC_DIG;
  localparam int unsigned DW      = NDIG * 4;
  localparam int unsigned BW      = DEC_DIG * 4;
  localparam int unsigned HW      = HEX_DIG * 4;
  localparam int unsigned IW      = $clog2(NDIG + 2);
  localparam int unsigned CW      = $clog2(WIDTH + 1);

  localparam logic [1:0] FMT_DEC = 2'd0;
  localparam logic [1:0] FMT_HEX = 2'd1;
  localparam logic [1:0] FMT_BIN = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  // One double-dabble step: add-3 correction on every BCD digit, then shift in the next bit
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] bcd, input logic bit_in);
    logic [BW-1:0] adj;
    adj = bcd;
    for (int k = 0; k < int'(DEC_DIG); k++) begin
      if (adj[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = adj[k*4 +: 4] + 4'd3;
    end
    return {adj[BW-2:0], bit_in};
  endfunction

  // Index of the most significant non-zero digit, 0 when the buffer is all zero
  function automatic logic [IW-1:0] msd_of(input logic [DW-1:0] dig);
    logic [IW-1:0] msd;
    msd = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (dig[k*4 +: 4] != 4'd0) msd = IW'(k);
    end
    return msd;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       fmt_q, fmt_d;
  logic             pad_q, pad_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    msd_q, msd_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
`ifdef FMT_NUM_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
`endif

  logic             emit_go;
  logic             ld_char;
  logic [3:0]       dig_sel;
  logic [HW-1:0]    hex_val;

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d     = state_q;
    fmt_d       = fmt_q;
    pad_d       = pad_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    idx_d       = idx_q;
    msd_d       = msd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef FMT_NUM_SIGNED_EN
    sgn_d       = sgn_q;
    neg_d       = neg_q;
`endif
    emit_go     = 1'b0;
    ld_char     = 1'b0;
    dig_sel     = 4'd0;
    hex_val     = HW'(in_value);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          fmt_d = (in_fmt == 2'd3) ? FMT_HEX : in_fmt;
          pad_d = in_pad;
          cnt_d = '0;
          dig_d = '0;
`ifdef FMT_NUM_SIGNED_EN
          sgn_d   = in_signed && (fmt_d == FMT_DEC);
          neg_d   = sgn_d && in_value[WIDTH-1];
          shreg_d = neg_d ? (~in_value + WIDTH'(1)) : in_value;
`else
          shreg_d = in_value;
`endif
          if (fmt_d == FMT_DEC) begin
            state_d = S_CONV;
          end else begin
            if (fmt_d == FMT_HEX) begin
              dig_d = DW'(hex_val);
            end else begin
              for (int k = 0; k < int'(WIDTH); k++) dig_d[k*4 +: 4] = {3'b000, in_value[k]};
            end
            state_d = S_EMIT;
            emit_go = 1'b1;
          end
        end
      end

      S_CONV: begin
        dig_d   = DW'(dabble(dig_q[BW-1:0], shreg_q[WIDTH-1]));
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_EMIT;
          emit_go = 1'b1;
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'h00;
          end else begin
            idx_d   = idx_q - IW'(1);
            ld_char = 1'b1;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = 8'h00;
      end
    endcase

    // Field start: padded width, or jump straight to the first significant digit
    if (emit_go) begin
      msd_d = msd_of(dig_d);
      if (pad_d) begin
        case (fmt_d)
          FMT_DEC: begin
`ifdef FMT_NUM_SIGNED_EN
            idx_d = sgn_d ? IW'(DEC_DIG) : IW'(DEC_DIG - 1);
`else
            idx_d = IW'(DEC_DIG - 1);
`endif
          end
          FMT_HEX: idx_d = IW'(HEX_DIG - 1);
          default: idx_d = IW'(WIDTH - 1);
        endcase
      end else begin
        idx_d = msd_d;
`ifdef FMT_NUM_SIGNED_EN
        if (neg_d) idx_d = msd_d + IW'(1);
`endif
      end
      ld_char = 1'b1;
    end

    // Character at idx_d: leading positions of a decimal field become spaces (or the sign)
    if (ld_char) begin
      dig_sel     = 4'(dig_d >> (32'(idx_d) * 32'd4));
      out_data_d  = 8'h30 + {4'h0, dig_sel};
      if ((fmt_d == FMT_HEX) && (dig_sel > 4'd9)) begin
        out_data_d = 8'h57 + {4'h0, dig_sel};
      end else if ((fmt_d == FMT_DEC) && (idx_d > msd_d)) begin
        out_data_d = 8'h20;
      end
`ifdef FMT_NUM_SIGNED_EN
      if ((fmt_d == FMT_DEC) && neg_d && (idx_d == msd_d + IW'(1))) out_data_d = 8'h2d;
`endif
      out_valid_d = 1'b1;
      out_last_d  = (idx_d == '0);
    end

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fmt_q       <= FMT_DEC;
      pad_q       <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dig_q       <= '0;
      idx_q       <= '0;
      msd_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef FMT_NUM_SIGNED_EN
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      pad_q       <= pad_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      idx_q       <= idx_d;
      msd_q       <= msd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef FMT_NUM_SIGNED_EN
      sgn_q       <= sgn_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fmt_num_ascii.sv
// Directed bench for fmt_num_ascii (WIDTH=16): vector table plus reset and back-pressure sequences.
module tb_fmt_num_ascii;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_value = '0;
  logic [1:0]   in_fmt = 2'd0;
  logic         in_pad = 1'b0;
  logic         in_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  fmt_num_ascii #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_fmt    (in_fmt),
    .in_pad    (in_pad),
`ifdef FMT_NUM_SIGNED_EN
    .in_signed (in_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] v;
    logic [1:0]   f;
    logic         p;
    logic         s;
    string        exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [W-1:0] v, input logic [1:0] f, input logic p, input logic s,
                     input string exp, input int lat);
    vec_t t;
    t.v = v; t.f = f; t.p = p; t.s = s; t.exp = exp; t.lat = lat;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // Issue one request and collect the field; inputs are scrambled right after the accept edge
  task automatic run_field(input logic [W-1:0] v, input logic [1:0] f, input logic p, input logic s,
                           input bit rnd, output string got, output int lat, output bit done,
                           output int rdy_err, output int hold_err, output int after_err);
    int   cyc;
    logic pv, pr, pl;
    logic [7:0] pd;
    got = ""; lat = -1; done = 1'b0; rdy_err = 0; hold_err = 0; after_err = 0;
    cyc = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00; pl = 1'b0;
    @(negedge clk);
    if (!in_ready) rdy_err++;
    in_valid = 1'b1; in_value = v; in_fmt = f; in_pad = p; in_signed = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_value = ~v; in_fmt = ~f; in_pad = ~p; in_signed = ~s;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) hold_err++;
      if (in_ready) rdy_err++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && lat < 0) lat = cyc + 1;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      @(posedge clk);
      cyc++;
      if (pv && pr) begin
        got = $sformatf("%s%c", got, pd);
        if (pl) done = 1'b1;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (!in_ready || out_valid || busy) after_err++;
  endtask

  task automatic check_vec(input string tag, input vec_t t, input bit rnd);
    string got;
    int    lat, rdy_err, hold_err, after_err;
    bit    done;
    run_field(t.v, t.f, t.p, t.s, rnd, got, lat, done, rdy_err, hold_err, after_err);
    chk({tag, "_done"}, longint'(done), 1);
    chk_str({tag, "_str"}, got, t.exp);
    if (!rnd) chk({tag, "_latency"}, lat, t.lat);
    chk({tag, "_in_ready_during"}, rdy_err, 0);
    chk({tag, "_idle_after"}, after_err, 0);
    if (rnd) chk({tag, "_hold_under_stall"}, hold_err, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_data"}, longint'(out_data), 0);
    chk({tag, "_out_last"}, longint'(out_last), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
  endtask

  task automatic quiet_after_reset(input string tag);
    int err;
    err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy || !in_ready) err++;
    end
    chk({tag, "_no_partial_output"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  t;
    int    seen;

    add(16'h001a, 2'd0, 1'b0, 1'b0, "26", 17);
    add(16'h001a, 2'd0, 1'b1, 1'b0, "   26", 17);
    add(16'h001a, 2'd1, 1'b1, 1'b0, "001a", 1);
    add(16'h001a, 2'd1, 1'b0, 1'b0, "1a", 1);
    add(16'h001a, 2'd2, 1'b0, 1'b0, "11010", 1);
    add(16'h0000, 2'd0, 1'b0, 1'b0, "0", 17);
    add(16'h0000, 2'd1, 1'b0, 1'b0, "0", 1);
    add(16'h0000, 2'd2, 1'b0, 1'b0, "0", 1);
    add(16'h0000, 2'd0, 1'b1, 1'b0, "    0", 17);
    add(16'h001a, 2'd3, 1'b0, 1'b0, "1a", 1);
    add(16'hffff, 2'd0, 1'b1, 1'b0, "65535", 17);
    add(16'h2710, 2'd0, 1'b0, 1'b0, "10000", 17);
    add(16'h0009, 2'd0, 1'b0, 1'b0, "9", 17);
    add(16'hbeef, 2'd1, 1'b0, 1'b0, "beef", 1);
    add(16'h0100, 2'd1, 1'b0, 1'b0, "100", 1);
    add(16'h0000, 2'd2, 1'b1, 1'b0, "0000000000000000", 1);
    add(16'h00a5, 2'd2, 1'b1, 1'b0, "0000000010100101", 1);
`ifdef FMT_NUM_SIGNED_EN
    add(16'hffff, 2'd0, 1'b0, 1'b1, "-1", 17);
    add(16'hffff, 2'd0, 1'b1, 1'b1, "    -1", 17);
    add(16'h8000, 2'd0, 1'b0, 1'b1, "-32768", 17);
    add(16'h8000, 2'd0, 1'b1, 1'b1, "-32768", 17);
    add(16'h001a, 2'd0, 1'b1, 1'b1, "    26", 17);
    add(16'h8000, 2'd1, 1'b0, 1'b1, "8000", 1);
`else
    add(16'hffff, 2'd0, 1'b0, 1'b0, "65535", 17);
`endif

    // Power-on reset values
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      check_vec($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Random back-pressure on a hex field
    t.v = 16'hffff; t.f = 2'd1; t.p = 1'b1; t.s = 1'b0; t.exp = "ffff"; t.lat = 1;
    for (int r = 0; r < 3; r++) check_vec($sformatf("stall%0d", r), t, 1'b1);
    t.v = 16'h04d2; t.f = 2'd0; t.p = 1'b1; t.s = 1'b0; t.exp = " 1234"; t.lat = 17;
    check_vec("stall_dec", t, 1'b1);

    // Reset in the middle of a decimal conversion
    @(negedge clk);
    in_valid = 1'b1; in_value = 16'h1234; in_fmt = 2'd0; in_pad = 1'b1; in_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("conv_busy", longint'(busy), 1);
    chk("conv_in_ready", longint'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_conv");
    quiet_after_reset("rst_conv");
    t.v = 16'h0135; t.f = 2'd0; t.p = 1'b0; t.s = 1'b0; t.exp = "309"; t.lat = 17;
    check_vec("post_rst_conv", t, 1'b0);

    // Reset while a stalled hex field is being emitted
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 16'hbeef; in_fmt = 2'd1; in_pad = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("emit_valid_seen", seen, 1);
    chk("emit_first_char", longint'(out_data), 8'h62);
    repeat (2) @(posedge clk);
    #2;
    chk("emit_held_char", longint'(out_data), 8'h62);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_emit");
    out_ready = 1'b1;
    quiet_after_reset("rst_emit");
    t.v = 16'h00c3; t.f = 2'd1; t.p = 1'b0; t.s = 1'b0; t.exp = "c3"; t.lat = 1;
    check_vec("post_rst_emit", t, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
